// File: rtl/nts_pkg.sv
// rtl/nts_pkg.sv - shared constants and TX arbiter state encoding
package nts_pkg;

  localparam int LAST_DATA_VALID_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nts_rr_picker.sv
// rtl/nts_rr_picker.sv - rotating-priority pick over a request vector
// Search begins one above i_ptr and wraps, so the last winner has lowest priority.
module nts_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_index
);

  always_comb begin
    int cand;
    cand    = 0;
    o_found = 1'b0;
    o_index = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(i_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!o_found && i_req[cand[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/nts_tx_arbiter.sv
// rtl/nts_tx_arbiter.sv - round-robin merge of engine TX packet interfaces onto one extractor port
// One packet per grant; a RELEASE bubble lets the engine drop packet_available before re-arbitration.
module nts_tx_arbiter
  import nts_pkg::*;
#(
  parameter int ENGINES        = 4,
  parameter int MAC_DATA_WIDTH = 64,
  parameter int IDX_WIDTH      = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
  input  logic                                       i_clk,
  input  logic                                       i_areset_n,
  input  logic [ENGINES-1:0]                         i_engine_packet_available,
  output logic [ENGINES-1:0]                         o_engine_packet_read,
  input  logic [ENGINES-1:0]                         i_engine_fifo_empty,
  output logic [ENGINES-1:0]                         o_engine_fifo_rd_start,
  input  logic [ENGINES-1:0]                         i_engine_fifo_rd_valid,
  input  logic [MAC_DATA_WIDTH*ENGINES-1:0]          i_engine_fifo_rd_data,
  input  logic [LAST_DATA_VALID_WIDTH*ENGINES-1:0]   i_engine_bytes_last_word,
  output logic                                       o_packet_available,
  input  logic                                       i_packet_read,
  output logic                                       o_fifo_empty,
  input  logic                                       i_fifo_rd_start,
  output logic                                       o_fifo_rd_valid,
  output logic [MAC_DATA_WIDTH-1:0]                  o_fifo_rd_data,
  output logic [LAST_DATA_VALID_WIDTH-1:0]           o_bytes_last_word,
  output logic                                       o_grant_valid,
  output logic [IDX_WIDTH-1:0]                       o_grant_index,
  output logic [31:0]                                o_packets_forwarded
);

  localparam int BLW = LAST_DATA_VALID_WIDTH;

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;

  logic                 pick_found;
  logic [IDX_WIDTH-1:0] pick_index;
  logic                 grant_active;

  logic                      sel_avail;
  logic                      sel_empty;
  logic                      sel_valid;
  logic [MAC_DATA_WIDTH-1:0] sel_data;
  logic [BLW-1:0]            sel_blw;

  nts_rr_picker #(
    .N     (ENGINES),
    .IDX_W (IDX_WIDTH)
  ) u_picker (
    .i_req   (i_engine_packet_available),
    .i_ptr   (ptr_q),
    .o_found (pick_found),
    .o_index (pick_index)
  );

  // Gating with reset makes an asserted reset drop the grant in the same cycle.
  assign grant_active = (state_q == GRANT) && i_areset_n;

  always_comb begin
    sel_avail              = 1'b0;
    sel_empty              = 1'b1;
    sel_valid              = 1'b0;
    sel_data               = '0;
    sel_blw                = '0;
    o_engine_packet_read   = '0;
    o_engine_fifo_rd_start = '0;
    for (int e = 0; e < ENGINES; e++) begin
      if (grant_idx_q == IDX_WIDTH'(e)) begin
        sel_avail = i_engine_packet_available[e];
        sel_empty = i_engine_fifo_empty[e];
        sel_valid = i_engine_fifo_rd_valid[e];
        sel_data  = i_engine_fifo_rd_data[e*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
        sel_blw   = i_engine_bytes_last_word[e*BLW +: BLW];
        o_engine_packet_read[e]   = grant_active & i_packet_read;
        o_engine_fifo_rd_start[e] = grant_active & i_fifo_rd_start;
      end
    end
  end

  always_comb begin
    o_packet_available = 1'b0;
    o_fifo_empty       = 1'b1;
    o_fifo_rd_valid    = 1'b0;
    o_fifo_rd_data     = '0;
    o_bytes_last_word  = '0;
    if (grant_active) begin
      o_packet_available = sel_avail;
      o_fifo_empty       = sel_empty;
      o_fifo_rd_valid    = sel_valid;
      o_fifo_rd_data     = sel_data;
      o_bytes_last_word  = sel_blw;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    pkt_cnt_d   = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_index;
          ptr_d       = pick_index;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // A read coinciding with the available drop still counts as completed.
        if (i_packet_read) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = RELEASE;
        end else if (!sel_avail) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_areset_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_WIDTH'(ENGINES - 1);
      grant_idx_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign o_grant_valid       = grant_active;
  assign o_grant_index       = grant_idx_q;
  assign o_packets_forwarded = pkt_cnt_q;

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// tb/tb_nts_tx_arbiter.sv - directed self-checking bench for nts_tx_arbiter
module tb_nts_tx_arbiter;

  localparam int ENG = 4;
  localparam int W   = 64;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [ENG-1:0] avail;
  logic [ENG-1:0] e_pr;
  logic [ENG-1:0] empty;
  logic [ENG-1:0] e_rs;
  logic [ENG-1:0] rd_valid;
  logic [W*ENG-1:0] rd_data;
  logic [4*ENG-1:0] blw;
  logic           pa;
  logic           pr;
  logic           fe;
  logic           rs;
  logic           fv;
  logic [W-1:0]   fd;
  logic [3:0]     fb;
  logic           gv;
  logic [IW-1:0]  gi;
  logic [31:0]    cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nts_tx_arbiter #(.ENGINES(ENG), .MAC_DATA_WIDTH(W)) dut (
    .i_clk                     (clk),
    .i_areset_n                (resetn),
    .i_engine_packet_available (avail),
    .o_engine_packet_read      (e_pr),
    .i_engine_fifo_empty       (empty),
    .o_engine_fifo_rd_start    (e_rs),
    .i_engine_fifo_rd_valid    (rd_valid),
    .i_engine_fifo_rd_data     (rd_data),
    .i_engine_bytes_last_word  (blw),
    .o_packet_available        (pa),
    .i_packet_read             (pr),
    .o_fifo_empty              (fe),
    .i_fifo_rd_start           (rs),
    .o_fifo_rd_valid           (fv),
    .o_fifo_rd_data            (fd),
    .o_bytes_last_word         (fb),
    .o_grant_valid             (gv),
    .o_grant_index             (gi),
    .o_packets_forwarded       (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".pkt_avail"}, 64'(pa), 64'd0);
    chk({tag, ".fifo_empty"}, 64'(fe), 64'd1);
    chk({tag, ".rd_valid"}, 64'(fv), 64'd0);
    chk({tag, ".rd_data"}, fd, 64'd0);
    chk({tag, ".blw"}, 64'(fb), 64'd0);
    chk({tag, ".grant_valid"}, 64'(gv), 64'd0);
    chk({tag, ".eng_pkt_read"}, 64'(e_pr), 64'd0);
    chk({tag, ".eng_rd_start"}, 64'(e_rs), 64'd0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_g;
    // Reset with every engine requesting and extractor strobes driven high.
    resetn   = 1'b0;
    avail    = 4'hF;
    empty    = 4'h0;
    rd_valid = 4'hF;
    rd_data  = {4{64'h5555_5555_5555_5555}};
    blw      = 16'hFFFF;
    pr       = 1'b1;
    rs       = 1'b1;
    nxt();
    nxt();
    chk_idle("reset");
    chk("reset.grant_index", 64'(gi), 64'd0);
    chk("reset.counter", 64'(cnt), 64'd0);

    pr     = 1'b0;
    rs     = 1'b0;
    resetn = 1'b1;
    nxt();
    chk("first.grant_valid", 64'(gv), 64'd1);
    chk("first.grant_index", 64'(gi), 64'd0);
    chk("first.pkt_avail", 64'(pa), 64'd1);

    // Round robin with all engines requesting: 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'(g % ENG);
      if (g > 0) begin
        chk("rr.grant_valid", 64'(gv), 64'd1);
        chk("rr.grant_index", 64'(gi), 64'(exp_g));
      end
      repeat (4) nxt();
      pr = 1'b1;
      #1;
      chk("rr.eng_pkt_read", 64'(e_pr), 64'(4'b0001 << exp_g));
      nxt();
      pr = 1'b0;
      if (g == 4) avail = 4'h0;
      #1;
      chk("rr.release_gv", 64'(gv), 64'd0);
      chk("rr.release_pa", 64'(pa), 64'd0);
      nxt();
      chk("rr.idle_pa", 64'(pa), 64'd0);
      nxt();
    end
    chk("rr.counter", 64'(cnt), 64'd5);
    chk_idle("rr.parked");

    // Data mux: only engine 2 requests; other lanes carry distinct decoys.
    avail    = 4'b0100;
    empty    = 4'b1011;
    rd_valid = 4'b0100;
    blw      = {4'hA, 4'h5, 4'hC, 4'h3};
    rd_data  = {64'h3333_3333_3333_3333, 64'hDEADBEEF_00000002,
                64'h1111_1111_1111_1111, 64'h0000_0000_0F0F_0F0F};
    nxt();
    chk("mux.grant_index", 64'(gi), 64'd2);
    chk("mux.pkt_avail", 64'(pa), 64'd1);
    chk("mux.rd_data", fd, 64'hDEADBEEF_00000002);
    chk("mux.rd_valid", 64'(fv), 64'd1);
    chk("mux.fifo_empty", 64'(fe), 64'd0);
    chk("mux.blw", 64'(fb), 64'd5);
    rd_data[2*W +: W] = 64'hCAFEF00D_12345678;
    #1;
    chk("mux.same_cycle_data", fd, 64'hCAFEF00D_12345678);
    rs = 1'b1;
    #1;
    chk("mux.eng_rd_start", 64'(e_rs), 64'b0100);
    chk("mux.no_pkt_read", 64'(e_pr), 64'd0);
    rs = 1'b0;
    pr = 1'b1;
    #1;
    chk("mux.eng_pkt_read", 64'(e_pr), 64'b0100);
    nxt();
    pr    = 1'b0;
    avail = 4'h0;
    #1;
    chk("mux.counter", 64'(cnt), 64'd6);
    chk_idle("mux.release");
    nxt();

    // Abort: engine 1 withdraws without a read.
    avail = 4'b0010;
    nxt();
    chk("abort.grant_index", 64'(gi), 64'd1);
    chk("abort.grant_valid", 64'(gv), 64'd1);
    avail = 4'b1001;
    #1;
    chk("abort.pkt_avail_drop", 64'(pa), 64'd0);
    nxt();
    chk_idle("abort.release");
    chk("abort.counter", 64'(cnt), 64'd6);
    nxt();
    nxt();
    chk("abort.next_grant", 64'(gi), 64'd3);
    chk("abort.next_gv", 64'(gv), 64'd1);

    // Read and available drop in the same cycle.
    avail = 4'b0001;
    pr    = 1'b1;
    #1;
    chk("simul.eng_pkt_read", 64'(e_pr), 64'b1000);
    nxt();
    chk("simul.counter", 64'(cnt), 64'd7);
    chk("simul.no_second_pulse", 64'(e_pr), 64'd0);
    pr = 1'b0;
    nxt();
    nxt();
    chk("wrap.grant_index", 64'(gi), 64'd0);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    pr = 1'b1;
    #1;
    chk("wrap.preload", 64'(cnt), 64'hFFFF_FFFF);
    nxt();
    pr = 1'b0;
    #1;
    chk("wrap.counter", 64'(cnt), 64'd0);
    chk("wrap.release_gv", 64'(gv), 64'd0);

    // Reset in the middle of a grant.
    avail = 4'hF;
    nxt();
    nxt();
    chk("midrst.grant_index", 64'(gi), 64'd1);
    chk("midrst.grant_valid", 64'(gv), 64'd1);
    resetn = 1'b0;
    pr     = 1'b1;
    rs     = 1'b1;
    #1;
    chk("midrst.eng_pkt_read", 64'(e_pr), 64'd0);
    chk("midrst.eng_rd_start", 64'(e_rs), 64'd0);
    chk("midrst.gv_drop", 64'(gv), 64'd0);
    nxt();
    chk_idle("midrst.after");
    chk("midrst.grant_index0", 64'(gi), 64'd0);
    chk("midrst.counter", 64'(cnt), 64'd0);
    pr     = 1'b0;
    rs     = 1'b0;
    resetn = 1'b1;
    nxt();
    chk("midrst.regrant_index", 64'(gi), 64'd0);
    chk("midrst.regrant_gv", 64'(gv), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nts_tx_arbiter.md
Name: nts_tx_arbiter

Overview:
Round-robin arbiter that merges the TX-side packet interfaces of ENGINES NTS engines onto the single extractor TX interface. It lifts the single-engine restriction at the engine/extractor boundary. Each granted engine streams exactly one packet through, then the grant is released and the next requester is chosen fairly. It sits between the engine array and nts_extractor, and exposes grant state and a forwarded-packet counter for debug.

Parameters:
ENGINES, 4, number of engines; legal range 1..16.
MAC_DATA_WIDTH, 64, FIFO read data width.
IDX_WIDTH, ENGINES>1 ? $clog2(ENGINES) : 1, width of the grant index (derived; do not override).

Ports:
i_clk  in  1  clock.
i_areset_n  in  1  reset; synchronous, active-low.
i_engine_packet_available  in  ENGINES  per-engine TX packet ready.
o_engine_packet_read  out  ENGINES  per-engine packet consumed pulse.
i_engine_fifo_empty  in  ENGINES  per-engine TX FIFO empty.
o_engine_fifo_rd_start  out  ENGINES  per-engine FIFO read start pulse.
i_engine_fifo_rd_valid  in  ENGINES  per-engine read data valid.
i_engine_fifo_rd_data  in  MAC_DATA_WIDTH*ENGINES  per-engine read data; engine k occupies slice [k*W +: W].
i_engine_bytes_last_word  in  4*ENGINES  per-engine valid bytes in last word.
o_packet_available  out  1  to extractor.
i_packet_read  in  1  from extractor.
o_fifo_empty  out  1  to extractor.
i_fifo_rd_start  in  1  from extractor.
o_fifo_rd_valid  out  1  to extractor.
o_fifo_rd_data  out  MAC_DATA_WIDTH  to extractor.
o_bytes_last_word  out  4  to extractor.
o_grant_valid  out  1  a grant is held.
o_grant_index  out  IDX_WIDTH  currently or last granted engine.
o_packets_forwarded  out  32  count of completed packet_read handshakes; wraps.

Behaviour:
- Reset: while i_areset_n=0 at a clock edge, all registers are cleared.
  - State returns to IDLE.
  - Round-robin pointer is set to ENGINES-1, so engine 0 has first priority.
  - o_grant_valid=0, o_grant_index=0, o_packets_forwarded=0.
  - Reset mid-packet drops the grant immediately. No packet_read is issued for the dropped grant.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - Search i_engine_packet_available starting at ptr+1 modulo ENGINES, ascending.
  - If the first set bit is k: register grant index k, set ptr<=k, go to GRANT.
  - If none is set, stay in IDLE.
  - Arbitration takes 1 cycle: o_packet_available rises the cycle after the engine's request is sampled.
- GRANT:
  - o_grant_valid=1.
  - Combinational mux from the granted engine: o_packet_available, o_fifo_empty, o_fifo_rd_valid, o_fifo_rd_data, o_bytes_last_word. The data path has zero added latency.
  - i_fifo_rd_start routes only to o_engine_fifo_rd_start[grant].
  - i_packet_read routes only to o_engine_packet_read[grant].
  - On i_packet_read=1: o_packets_forwarded increments by 1 (32-bit wrap), then go to RELEASE.
  - Abort: if the granted engine's packet_available=0 and i_packet_read=0, go to RELEASE without incrementing.
  - If packet_read and the available drop occur in the same cycle, the event counts as a completed read.
- RELEASE:
  - Lasts 1 cycle, so the engine can drop packet_available.
  - Outputs are idle; go to IDLE.
- Idle output values (IDLE, RELEASE and reset): o_packet_available=0, o_fifo_empty=1, o_fifo_rd_valid=0, o_fifo_rd_data=0, o_bytes_last_word=0.
  - All o_engine_* outputs are 0.
  - i_packet_read and i_fifo_rd_start are ignored.
- Non-granted engines: always see o_engine_packet_read=0 and o_engine_fifo_rd_start=0.
- ENGINES=1: behaves as a pass-through with the 1-cycle arbitration delay and the RELEASE bubble. o_grant_index is always 0.
- Fairness: with all engines requesting continuously, grants cycle 0,1,...,ENGINES-1,0.
  - Maximum wait for any requester is ENGINES packets.

Decomposition:
- Shared package nts_pkg:
  - Constant LAST_DATA_VALID_WIDTH=4.
  - FSM state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2).
- One sub-module: nts_rr_picker (parameter N). Combinational rotating priority pick over a request vector and pointer. Outputs are found and index. It is reusable for a future RX-side dispatcher fan-out.

Test Plan:
1. Reset/idle: i_areset_n=0 for 2 cycles with all available=1, then hold reset → every output at its idle value, o_packets_forwarded=0. Release reset → first grant is index 0; o_packet_available=1 one cycle later.
2. Round-robin: ENGINES=4, all available=1, extractor pulses packet_read 5 cycles after each grant → grant order 0,1,2,3,0. Counter reaches 5. Each o_engine_packet_read pulse appears only on the granted bit.
3. Data mux: only engine 2 requests, supplying data 64'hDEADBEEF_00000002, rd_valid and bytes_last_word=4'd5 → the same values appear unchanged on the extractor side in the same cycle. Extractor rd_start reaches only o_engine_fifo_rd_start[2].
4. Abort: engine 1 is granted and drops available without packet_read → RELEASE then IDLE. Counter unchanged. Next grant goes to the next requester after 1.
5. Simultaneous: packet_read=1 in the same cycle the engine's available drops → counter +1 and a single o_engine_packet_read pulse. Also: counter preloaded (force) to 32'hFFFF_FFFF plus one read → 0.
6. Reset mid-packet: assert reset while in GRANT → the next cycle is IDLE outputs with ptr=ENGINES-1. No spurious o_engine_packet_read.
